// File: rtl/msg_writer.sv
// Stages a byte message and plays it out as consecutive wr strobes, then a gap,
// a one-cycle disp trigger, a second gap and a done pulse.
module msg_writer #(
   parameter int DEPTH = 16,
   parameter int GAP   = 3,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          push,
   input  logic [7:0]    push_dat,
   input  logic          start,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          busy,
   output logic          done,
   output logic          wr,
   output logic [7:0]    dat,
   output logic          disp
);

   localparam int PW = $clog2(DEPTH);
   localparam int GW = $clog2(GAP + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

   typedef enum logic [2:0] {IDLE, WRITE, GAP1, DISP, GAP2, DONE} state_t;

   state_t        state_q, state_d;
   logic          go_q, go_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          wr_q, wr_d;
   logic [7:0]    dat_q, dat_d;
   logic          disp_q, disp_d;
   logic          done_q, done_d;
   logic          push_ok;
   logic [7:0]    mem_q [DEPTH];

   // A sampled start is held in go_q for one cycle so playback begins on the
   // following edge with the same-cycle push already counted.
   always_comb begin
      state_d = state_q;
      go_d    = go_q;
      count_d = count_q;
      full_d  = full_q;
      ptr_d   = ptr_q;
      gap_d   = gap_q;
      wr_d    = 1'b0;
      dat_d   = '0;
      disp_d  = 1'b0;
      done_d  = 1'b0;
      push_ok = push && !full_q && (state_q == IDLE) && !go_q;
      if (push_ok) begin
         count_d = count_q + CW'(1);
         full_d  = ((count_q + CW'(1)) == DEPTH_C);
      end
      case (state_q)
         IDLE: begin
            if (go_q) begin
               go_d = 1'b0;
               if (count_q != '0) begin
                  state_d = WRITE;
                  wr_d    = 1'b1;
                  dat_d   = mem_q[0];
                  ptr_d   = '0;
               end else begin
                  state_d = GAP1;
                  gap_d   = GAP_LOAD;
               end
            end else if (start) begin
               go_d = 1'b1;
            end
         end
         WRITE: begin
            if (CW'(ptr_q) == (count_q - CW'(1))) begin
               state_d = GAP1;
               gap_d   = GAP_LOAD;
            end else begin
               ptr_d = ptr_q + PW'(1);
               wr_d  = 1'b1;
               dat_d = mem_q[ptr_q + PW'(1)];
            end
         end
         GAP1: begin
            if (gap_q == '0) begin
               state_d = DISP;
               disp_d  = 1'b1;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         DISP: begin
            state_d = GAP2;
            gap_d   = GAP_LOAD;
         end
         GAP2: begin
            if (gap_q == '0) begin
               state_d = DONE;
               done_d  = 1'b1;
               count_d = '0;
               full_d  = 1'b0;
               ptr_d   = '0;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         go_q    <= 1'b0;
         count_q <= '0;
         full_q  <= 1'b0;
         ptr_q   <= '0;
         gap_q   <= '0;
         wr_q    <= 1'b0;
         dat_q   <= '0;
         disp_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         go_q    <= go_d;
         count_q <= count_d;
         full_q  <= full_d;
         ptr_q   <= ptr_d;
         gap_q   <= gap_d;
         wr_q    <= wr_d;
         dat_q   <= dat_d;
         disp_q  <= disp_d;
         done_q  <= done_d;
      end
   end

   // Message storage carries no reset; stale bytes are never read past count.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[count_q[PW-1:0]] <= push_dat;
   end

   assign count = count_q;
   assign full  = full_q;
   assign busy  = (state_q != IDLE);
   assign done  = done_q;
   assign wr    = wr_q;
   assign dat   = dat_q;
   assign disp  = disp_q;

endmodule

// File: tb/tb_msg_writer.sv
// Randomized bench for msg_writer: a queue-based timeline model predicts every
// output each cycle, plus literal checks on the documented scenarios.
module tb_msg_writer;

   localparam int DEPTH = 16;
   localparam int GAP   = 3;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk;
   logic          rst_b;
   logic          push;
   logic [7:0]    push_dat;
   logic          start;
   logic [CW-1:0] count;
   logic          full;
   logic          busy;
   logic          done;
   logic          wr;
   logic [7:0]    dat;
   logic          disp;

   msg_writer #(.DEPTH(DEPTH), .GAP(GAP)) dut (
      .clk(clk), .rst_b(rst_b), .push(push), .push_dat(push_dat), .start(start),
      .count(count), .full(full), .busy(busy), .done(done), .wr(wr), .dat(dat),
      .disp(disp)
   );

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   // model: staged bytes, snapshot being played, t = cycles since the start edge
   byte unsigned mq[$];
   byte unsigned play[$];
   int t  = -1;
   int pc = 0;

   // observed events
   byte unsigned seen[$];
   int disp_cyc = -1;
   int done_cyc = -1;
   int disp_n = 0;
   int done_n = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         mq.delete();
         t = -1;
      end else begin
         if (t >= 0) begin
            t++;
            if (t == pc + 2*GAP + 3) t = -1;
         end else begin
            if (push && mq.size() < DEPTH) mq.push_back(push_dat);
            if (start) begin
               play = mq;
               pc   = mq.size();
               t    = 0;
            end
         end
         if (t == pc + 2*GAP + 2) mq.delete();
      end
   end

   always @(negedge clk) begin
      logic       e_wr;
      logic [7:0] e_dat;
      e_wr  = (t >= 1) && (t <= pc);
      e_dat = e_wr ? play[t-1] : 8'h00;
      chk("wr",    {31'd0, wr},   {31'd0, e_wr});
      chk("dat",   {24'd0, dat},  {24'd0, e_dat});
      chk("disp",  {31'd0, disp}, {31'd0, 1'(t == pc + GAP + 1)});
      chk("done",  {31'd0, done}, {31'd0, 1'(t == pc + 2*GAP + 2)});
      chk("busy",  {31'd0, busy}, {31'd0, 1'(t >= 1)});
      chk("count", 32'(count),    32'(mq.size()));
      chk("full",  {31'd0, full}, {31'd0, 1'(mq.size() == DEPTH)});
      if (wr === 1'b1) seen.push_back(dat);
      if (disp === 1'b1) begin disp_cyc = cyc; disp_n++; end
      if (done === 1'b1) begin done_cyc = cyc; done_n++; end
   end

   task automatic step(input logic p, input logic [7:0] d, input logic s);
      push = p; push_dat = d; start = s;
      @(posedge clk); #1;
      push = 1'b0; start = 1'b0; push_dat = 8'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_done(input bit noise, input logic [7:0] nb);
      int k;
      bit got;
      k = 0; got = 1'b0;
      while (!got && k < 200) begin
         if (noise) begin push = 1'b1; push_dat = nb; start = 1'($urandom_range(0, 1)); end
         @(negedge clk);
         got = (done === 1'b1);
         @(posedge clk); #1;
         k++;
      end
      push = 1'b0; start = 1'b0;
      chk("done_within_budget", {31'd0, got}, 32'd1);
   endtask

   initial begin
      logic [7:0] hello [11];
      int n0, nd, nq, c99, nb;
      hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64};
      push = 1'b0; start = 1'b0; push_dat = 8'h00; rst_b = 1'b1;
      #2 rst_b = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_full",  {31'd0, full}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_wr",    {31'd0, wr},   32'd0);
      chk("rst_dat",   {24'd0, dat},  32'd0);
      chk("rst_disp",  {31'd0, disp}, 32'd0);
      chk("rst_done",  {31'd0, done}, 32'd0);
      #20 rst_b = 1'b1;
      @(posedge clk); #1;

      // Hello World
      for (int i = 0; i < 11; i++) step(1'b1, hello[i], 1'b0);
      seen.delete(); disp_cyc = -1; done_cyc = -1;
      step(1'b0, 8'h00, 1'b1);
      n0 = cyc;
      wait_done(1'b0, 8'h00);
      chk("hello_len", 32'(seen.size()), 32'd11);
      for (int i = 0; i < 11 && i < seen.size(); i++) chk("hello_byte", 32'(seen[i]), 32'(hello[i]));
      chk("hello_disp_ofs", 32'(disp_cyc - n0), 32'd15);
      chk("hello_done_ofs", 32'(done_cyc - n0), 32'd19);
      idle(1);
      chk("hello_count0", 32'(count), 32'd0);

      // overflow: 17 pushes into 16 slots
      for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0);
      chk("ovf_count", 32'(count), 32'd16);
      chk("ovf_full", {31'd0, full}, 32'd1);
      seen.delete();
      step(1'b0, 8'h00, 1'b1);
      wait_done(1'b0, 8'h00);
      chk("ovf_len", 32'(seen.size()), 32'd16);
      for (int i = 0; i < 16 && i < seen.size(); i++) chk("ovf_byte", 32'(seen[i]), i);
      idle(1);

      // empty buffer
      seen.delete(); disp_cyc = -1; done_cyc = -1;
      step(1'b0, 8'h00, 1'b1);
      n0 = cyc;
      wait_done(1'b0, 8'h00);
      chk("empty_no_wr", 32'(seen.size()), 32'd0);
      chk("empty_disp_ofs", 32'(disp_cyc - n0), 32'd4);
      chk("empty_done_ofs", 32'(done_cyc - n0), 32'd8);
      idle(1);

      // push together with start
      step(1'b1, 8'h41, 1'b0);
      step(1'b1, 8'h42, 1'b0);
      seen.delete();
      step(1'b1, 8'h43, 1'b1);
      wait_done(1'b0, 8'h00);
      chk("same_len", 32'(seen.size()), 32'd3);
      if (seen.size() == 3) begin
         chk("same_b0", 32'(seen[0]), 32'h41);
         chk("same_b1", 32'(seen[1]), 32'h42);
         chk("same_b2", 32'(seen[2]), 32'h43);
      end
      idle(1);

      // start/push 0x99 while busy
      step(1'b1, 8'h10, 1'b0);
      step(1'b1, 8'h20, 1'b0);
      seen.delete();
      step(1'b0, 8'h00, 1'b1);
      nd = done_n;
      wait_done(1'b1, 8'h99);
      chk("busy_count0", 32'(count), 32'd0);
      idle(20);
      chk("busy_one_done", 32'(done_n - nd), 32'd1);
      c99 = 0;
      foreach (seen[i]) if (seen[i] == 8'h99) c99++;
      chk("busy_no_99", 32'(c99), 32'd0);
      chk("busy_len", 32'(seen.size()), 32'd2);

      // reset during 5th write
      for (int i = 0; i < 11; i++) step(1'b1, hello[i], 1'b0);
      step(1'b0, 8'h00, 1'b1);
      n0 = cyc;
      while (cyc < n0 + 5) @(posedge clk);
      #2 rst_b = 1'b0;
      #1;
      chk("mid_wr",   {31'd0, wr},   32'd0);
      chk("mid_dat",  {24'd0, dat},  32'd0);
      chk("mid_disp", {31'd0, disp}, 32'd0);
      chk("mid_busy", {31'd0, busy}, 32'd0);
      nd = done_n; nq = disp_n;
      @(posedge clk); #3 rst_b = 1'b1;
      @(posedge clk); #1;
      idle(25);
      chk("mid_no_disp", 32'(disp_n - nq), 32'd0);
      chk("mid_no_done", 32'(done_n - nd), 32'd0);
      chk("mid_count0", 32'(count), 32'd0);
      step(1'b1, 8'hA5, 1'b0);
      step(1'b1, 8'h5A, 1'b0);
      seen.delete();
      step(1'b0, 8'h00, 1'b1);
      wait_done(1'b0, 8'h00);
      chk("post_len", 32'(seen.size()), 32'd2);
      if (seen.size() == 2) begin
         chk("post_b0", 32'(seen[0]), 32'hA5);
         chk("post_b1", 32'(seen[1]), 32'h5A);
      end
      idle(1);

      // randomized rounds, judged by the model every cycle
      for (int r = 0; r < 40; r++) begin
         nb = $urandom_range(0, DEPTH + 2);
         for (int i = 0; i < nb; i++) begin
            step(1'b1, 8'($urandom), 1'b0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
         if (r % 7 == 3) begin
            idle($urandom_range(1, nb + 2*GAP + 3));
            #1 rst_b = 1'b0;
            #3 rst_b = 1'b1;
            idle(2);
         end else begin
            wait_done(1'($urandom_range(0, 1)), 8'($urandom));
            idle($urandom_range(1, 3));
         end
      end

      idle(3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/msg_writer.md
# msg_writer

Byte-stream writer that drives the `wr`/`dat`/`disp` interface of the memory-display `dut` from the host side. A message is staged into an internal buffer one byte per `push`. A `start` pulse then plays the bytes out as consecutive `wr` strobes, followed by a fixed idle gap, a one-cycle `disp` trigger, a second gap, and a `done` pulse. It replaces hand-written stimulus loops, so a test or an upstream controller can load a string and fire it with a single command.

## Interface
- `DEPTH`, default 16: message buffer capacity in bytes; ≥ 2.
- `GAP`, default 3: idle cycles after the last write and after `disp`; ≥ 1.
- `CW`, derived as $clog2(DEPTH+1): width of `count`.

Ports:
- `clk`: input, 1 bit. Single clock; all logic is on the rising edge.
- `rst_b`: input, 1 bit. Asynchronous, active-low reset.
- `push`: input, 1 bit. Stage `push_dat` into the buffer.
- `push_dat`: input, 8 bits. Byte to stage.
- `start`: input, 1 bit. Begin the playback sequence.
- `count`: output, CW bits. Number of bytes staged.
- `full`: output, 1 bit. High when `count == DEPTH`.
- `busy`: output, 1 bit. High in any state other than IDLE.
- `done`: output, 1 bit. One-cycle pulse when the sequence completes.
- `wr`: output, 1 bit. Write strobe to `dut`.
- `dat`: output, 8 bits. Write data to `dut`.
- `disp`: output, 1 bit. Display trigger to `dut`.

## Operation
- Reset: all of the following are 0 asynchronously: `count`, `full`, `busy`, `done`, `wr`, `dat`, `disp`. The state is IDLE and the read pointer is 0. Buffer contents are don't-care.
- Staging:
  - In IDLE, `push` with `!full` writes `push_dat` to `buf[count]` and increments `count`.
  - `push` when full, or in any state other than IDLE, is dropped silently; `count` is unchanged.
- FSM states: IDLE, WRITE, GAP1, DISP, GAP2, DONE.
  - IDLE → WRITE: on `start` with effective count > 0. Effective count includes a same-cycle accepted push.
  - IDLE → GAP1: on `start` with effective count == 0. No `wr` strobes are issued.
  - WRITE: `wr`=1 and `dat`=`buf[ptr]`; `ptr` increments each cycle. Go to GAP1 after `ptr == count-1`.
  - GAP1: `wr`=0 and `dat`=0 for GAP cycles, then go to DISP.
  - DISP: `disp`=1 for exactly one cycle, then go to GAP2.
  - GAP2: idle for GAP cycles, then go to DONE.
  - DONE: `done`=1 for one cycle. `count` and `ptr` clear to 0. Return to IDLE.
- `start` outside IDLE is ignored.
- Simultaneous `push` and `start` in IDLE: the push is accepted first, and playback includes that byte as the last one.
- Outputs:
  - `wr`, `dat`, `disp`, `done` are registered, with no combinational path from the inputs.
  - `dat` is 0 whenever `wr` is 0.
- Arithmetic:
  - `count` saturates at DEPTH.
  - `ptr` is a $clog2(DEPTH)-bit pointer and never wraps, because playback stops at `count-1`.
  - The gap counter is $clog2(GAP+1) bits and reloads on each gap entry.

## Timing
- `start` sampled at edge N with count = C > 0:
  - `wr` is high for edges N+1 through N+C; `busy` rises at N+1.
  - `dat` presents `buf[0..C-1]` in order, one byte per cycle, with no bubbles.
- `wr` falls at N+C+1.
- `disp` is high for the cycle starting at edge N+C+GAP+1.
- `done` is high for the cycle starting at edge N+C+2·GAP+2. `busy` falls together with `done`, and `count` reads 0 in that same cycle.
- Total occupancy is C + 2·GAP + 2 cycles. With C = 0, the same formula applies.
- Next `start` or `push` is accepted at the earliest in the cycle after `done`.
- Reset asserted mid-sequence: `wr`, `disp`, `done` drop immediately, with no partial `disp` or `done` afterwards. The staged message is discarded.
- `full` tracks `count` in the same cycle, so it is registered alongside it.

## Test plan
- Push "Hello World" (11 bytes), then `start`:
  - `wr` is high 11 consecutive cycles with `dat` = 0x48, 0x65, 0x6C, 0x6C, 0x6F, 0x20, 0x57, 0x6F, 0x72, 0x6C, 0x64.
  - Then 3 idle cycles, `disp` high for 1 cycle, 3 idle cycles, `done` for 1 cycle.
  - `count` returns to 0.
- With DEPTH=16, push 17 bytes 0x00..0x10:
  - `count` = 16 and `full` = 1; byte 0x10 is dropped.
  - Playback emits 0x00..0x0F only.
- `start` with empty buffer: no `wr`; `disp` is high 4 cycles after `start` is sampled; `done` 8 cycles after.
- Push 0x41, 0x42, then push 0x43 in the same cycle as `start`: playback emits 0x41, 0x42, 0x43 (3 strobes).
- `start` and `push` 0x99 while busy: no second sequence starts; `count` stays 0 after `done`; 0x99 never appears on `dat`.
- `rst_b` pulsed low during the 5th `wr` of an 11-byte message:
  - `wr`, `dat`, `disp`, `busy` are 0 immediately; `disp` and `done` never fire.
  - After release, a fresh 2-byte push and `start` plays back correctly.
